// File: rtl/apb_master_arbiter_if.sv
// APB4 requester-side bus bundle between the arbiter (master) and the
// shared completer (slave).
interface apb_master_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   paddr;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [2:0]              pprot;
    logic                    psel;
    logic                    penable;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output paddr, pwrite, pwdata, pstrb, pprot, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwrite, pwdata, pstrb, pprot, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB4 completer among NUM_REQ requesters,
// with SETUP/ACCESS sequencing and a wait-state watchdog.
module apb_master_arbiter #(
    parameter int          NUM_REQ        = 2,
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [2:0]  PPROT_VAL      = 3'b000
) (
    input  logic                               pclk,
    input  logic                               presetn,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_addr,
    input  logic [NUM_REQ-1:0]                 req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]    req_strb,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [DATA_WIDTH-1:0]              rsp_rdata,
    output logic                               rsp_err,
    apb_master_arbiter_if.master               apb
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e                 state_q, state_d;
    logic [GW-1:0]          last_q, last_d, owner_q, owner_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   write_q, write_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [SW-1:0]          strb_q, strb_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [CW-1:0]          wait_q, wait_d;

    logic                   win_found;
    logic [GW-1:0]          win_idx;
    int                     idx;

    // First pending requester searching upward from last_grant+1, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!win_found && req_valid[idx[GW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wait_d      = wait_q;
        req_ready   = '0;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    req_ready[win_idx] = 1'b1;
                    last_d  = win_idx;
                    owner_d = win_idx;
                    addr_d  = req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    write_d = req_write[win_idx];
                    wdata_d = req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    // Reads never carry byte strobes on APB4.
                    strb_d  = req_write[win_idx] ? req_strb[int'(win_idx)*SW +: SW] : '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                wait_d  = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (apb.pready) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d = write_q ? '0 : apb.prdata;
                    rsp_err_d   = apb.pslverr;
                    state_d     = IDLE;
                end else if (TIMEOUT_CYCLES != 0 && wait_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = IDLE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    wait_d = wait_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            last_q      <= GW'(NUM_REQ - 1);
            owner_q     <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            strb_q      <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wait_q      <= wait_d;
        end
    end

    assign apb.psel    = (state_q != IDLE);
    assign apb.penable = (state_q == ACCESS);
    assign apb.paddr   = addr_q;
    assign apb.pwrite  = write_q;
    assign apb.pwdata  = wdata_q;
    assign apb.pstrb   = strb_q;
    assign apb.pprot   = PPROT_VAL;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench: write/read, wait states, round-robin order, slave error,
// watchdog abort and mid-transfer reset on a 3-requester, timeout-4 instance.
module tb_apb_master_arbiter;
    localparam int NR = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              pclk = 1'b0;
    logic              presetn;
    logic [NR-1:0]     req_valid, req_ready, req_write, rsp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR*4-1:0]   req_strb;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    apb_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

    apb_master_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(4), .PPROT_VAL(3'b010)
    ) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write),
        .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .apb(apb)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] s);
        req_addr[i*AW +: AW] = a;
        req_write[i]         = w;
        req_wdata[i*DW +: DW] = d;
        req_strb[i*4 +: 4]   = s;
    endtask

    initial begin
        presetn = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;
        apb.pready = 1'b0; apb.pslverr = 1'b0; apb.prdata = '0;
        tick(); tick();
        chk("rst_psel", apb.psel, 0);
        chk("rst_penable", apb.penable, 0);
        chk("rst_paddr", apb.paddr, 0);
        chk("rst_pstrb", apb.pstrb, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("pprot", apb.pprot, 3'b010);
        presetn = 1'b1;
        tick();

        // Single write by requester 0, zero wait states
        set_req(0, 32'h10, 1'b1, 32'hA5A5_0001, 4'hF);
        req_valid = 3'b001; apb.pready = 1'b1;
        #1 chk("t1_ready", req_ready, 3'b001);
        tick(); req_valid = '0; #1;
        chk("t1_setup_psel", apb.psel, 1);
        chk("t1_setup_pen", apb.penable, 0);
        chk("t1_paddr", apb.paddr, 32'h10);
        chk("t1_pwrite", apb.pwrite, 1);
        chk("t1_pwdata", apb.pwdata, 32'hA5A5_0001);
        chk("t1_pstrb", apb.pstrb, 4'hF);
        tick();
        chk("t1_access_pen", apb.penable, 1);
        tick();
        chk("t1_rsp_valid", rsp_valid, 3'b001);
        chk("t1_rsp_err", rsp_err, 0);
        chk("t1_psel_off", apb.psel, 0);

        // Read by requester 1 with two wait states
        set_req(1, 32'h24, 1'b0, 32'h5555_5555, 4'hF);
        req_valid = 3'b010; apb.pready = 1'b0;
        #1 chk("t2_ready", req_ready, 3'b010);
        tick(); req_valid = '0; #1;
        chk("t2_pwrite", apb.pwrite, 0);
        chk("t2_pstrb", apb.pstrb, 0);
        chk("t2_paddr", apb.paddr, 32'h24);
        tick();
        chk("t2_pen_a1", apb.penable, 1);
        tick();
        chk("t2_pen_a2", apb.penable, 1);
        chk("t2_rsp_none", rsp_valid, 0);
        tick(); apb.pready = 1'b1; apb.prdata = 32'hDEAD_BEEF; #1;
        chk("t2_pen_a3", apb.penable, 1);
        tick(); apb.pready = 1'b0; apb.prdata = '0; #1;
        chk("t2_rsp_valid", rsp_valid, 3'b010);
        chk("t2_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("t2_rsp_err", rsp_err, 0);

        // Slave error on a write by requester 0, then normal read by 1
        set_req(0, 32'h30, 1'b1, 32'h0000_00FF, 4'h3);
        req_valid = 3'b001;
        #1 chk("t4_ready", req_ready, 3'b001);
        tick(); req_valid = '0; #1;
        tick(); apb.pready = 1'b1; apb.pslverr = 1'b1; #1;
        tick(); apb.pslverr = 1'b0; apb.prdata = 32'h1234_5678;
        set_req(1, 32'h34, 1'b0, 32'h0, 4'h0);
        req_valid = 3'b010; #1;
        chk("t4_rsp_valid", rsp_valid, 3'b001);
        chk("t4_rsp_err", rsp_err, 1);
        chk("t4_rsp_rdata", rsp_rdata, 0);
        chk("t4_next_ready", req_ready, 3'b010);
        tick(); req_valid = '0; #1;
        chk("t4_next_paddr", apb.paddr, 32'h34);
        tick(); tick();
        chk("t4_next_rsp", rsp_valid, 3'b010);
        chk("t4_next_err", rsp_err, 0);
        chk("t4_next_rdata", rsp_rdata, 32'h1234_5678);

        // Watchdog abort on requester 2, pready stuck low
        apb.pready = 1'b0; apb.prdata = 32'hFFFF_FFFF;
        set_req(2, 32'h40, 1'b0, 32'h0, 4'h0);
        req_valid = 3'b100;
        #1 chk("t5_ready", req_ready, 3'b100);
        tick(); req_valid = '0; #1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("t5_pen_%0d", c), apb.penable, 1);
        end
        tick();
        chk("t5_psel_off", apb.psel, 0);
        chk("t5_rsp_valid", rsp_valid, 3'b100);
        chk("t5_rsp_err", rsp_err, 1);
        chk("t5_rsp_rdata", rsp_rdata, 0);
        tick();
        chk("t5_rsp_once", rsp_valid, 0);
        chk("t5_idle", apb.psel, 0);

        // Reset during ACCESS by requester 1
        set_req(1, 32'h50, 1'b1, 32'hCAFE_0000, 4'hF);
        req_valid = 3'b010;
        #1 chk("t6_ready", req_ready, 3'b010);
        tick(); req_valid = '0; #1;
        tick();
        chk("t6_in_access", apb.penable, 1);
        presetn = 1'b0; #1;
        chk("t6_psel_rst", apb.psel, 0);
        chk("t6_pen_rst", apb.penable, 0);
        chk("t6_paddr_rst", apb.paddr, 0);
        tick(); presetn = 1'b1; apb.pready = 1'b1; #1;
        tick();
        chk("t6_no_rsp", rsp_valid, 0);

        // Round-robin with all requesters pending: 0,1,2,0,1,2
        for (int i = 0; i < NR; i++) set_req(i, 32'h100 + 32'(i) * 4, 1'b1, 32'h1000 + 32'(i), 4'hF);
        req_valid = 3'b111; #1;
        for (int j = 0; j < 6; j++) begin
            logic [2:0] oh;
            oh = 3'b001 << (j % 3);
            chk($sformatf("rr_ready_%0d", j), req_ready, oh);
            tick();
            chk($sformatf("rr_paddr_%0d", j), apb.paddr, 32'h100 + 32'(j % 3) * 4);
            tick(); tick();
            chk($sformatf("rr_rsp_%0d", j), rsp_valid, oh);
        end
        req_valid = '0; #1;
        tick();
        chk("rr_idle", apb.psel, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Shares one APB4 completer port, typically an APB-to-register-bus slave adapter front-end on a peripheral, among NUM_REQ native requesters. It arbitrates round-robin, sequences the APB SETUP/ACCESS phases, honours PREADY wait states, and returns read data and error status to the winning requester. A transfer whose PREADY never arrives is terminated by a wait-state watchdog with an error response. The block sits between internal bus masters (DMA, debug, CPU bridge) and the peripheral APB segment.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_WIDTH, 32, APB/requester address width
- DATA_WIDTH, 32, APB/requester data width (multiple of 8)
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort; 0 disables the watchdog
- PPROT_VAL, 3'b000, constant driven on pprot
- pclk  in  1  clock, all logic on rising edge
- presetn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  requester i has a pending transfer
- req_ready  out  NUM_REQ  one-hot acceptance strobe; fields of requester i captured on this cycle
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
- req_strb  in  NUM_REQ*DATA_WIDTH/8  flattened byte strobes
- rsp_valid  out  NUM_REQ  one-cycle one-hot completion pulse to the owning requester
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
- rsp_err  out  1  error (PSLVERR or timeout), valid with rsp_valid
- paddr, pwrite, pwdata, pstrb, pprot, psel, penable  out  APB4 requester-side signals
- prdata  in  DATA_WIDTH; pready  in  1; pslverr  in  1  APB4 completer responses

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: if any req_valid is set, the winner is the first set bit searching upward from (last_grant+1) mod NUM_REQ, wrapping around. req_ready[winner] is driven combinationally in that cycle. At the clock edge the block captures the winner's addr/write/wdata/strb, sets owner and last_grant to the winner, and moves to SETUP. If no req_valid is set, the FSM stays in IDLE and req_ready is 0.
- SETUP: psel=1, penable=0, APB fields driven from the captured registers. Next state is always ACCESS.
- ACCESS: psel=1, penable=1, fields held stable. If pready=1: capture prdata (reads; 0 for writes) and pslverr into rsp_rdata/rsp_err, pulse rsp_valid[owner] on the next cycle, then go to IDLE.
- Watchdog: wait_cnt clears on entry to ACCESS and increments each ACCESS cycle with pready=0. If TIMEOUT_CYCLES≠0 and pready=0 on the TIMEOUT_CYCLES-th ACCESS cycle, the transfer aborts: go to IDLE, drop psel/penable, respond with rsp_err=1 and rsp_rdata=0.
- pstrb is forced to 0 on reads (APB4 rule). pwdata is driven on reads but carries no meaning.
- A requester that drops req_valid before acceptance is simply skipped. Fields only need to be stable in the acceptance cycle.
- When rsp_valid is pulsed in IDLE, a new acceptance can occur in the same cycle.

## Timing
- Reset (async assert, sync deassert assumed at system level): state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), psel=penable=pwrite=0, paddr=pwdata=pstrb=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait_cnt=0. pprot=PPROT_VAL at all times.
- Accept at cycle T → SETUP T+1 → ACCESS T+2 → rsp_valid at T+3 with zero wait states; each wait state adds 1 cycle.
- Minimum issue interval between transfers is 3 cycles (IDLE, SETUP, ACCESS).
- Reset asserted mid-transfer: psel/penable drop immediately, no rsp_valid is issued, and the transfer is lost.
- pready/pslverr/prdata are sampled only in ACCESS and ignored in other states.
- wait_cnt width is clog2(TIMEOUT_CYCLES+1) and must not wrap before the abort fires.

## Test plan
- Single write, req 0, addr 0x10, data 0xA5A5_0001, strb 0xF, pready=1 → SETUP then ACCESS with pwrite=1, pstrb=0xF; rsp_valid[0] 3 cycles after accept; rsp_err=0.
- Read by req 1 with pready low for 2 ACCESS cycles, prdata=0xDEAD_BEEF → penable high for 3 cycles, pstrb=0, rsp_rdata=0xDEAD_BEEF at accept+5.
- NUM_REQ=3, all req_valid held high for 6 transfers → grant order 0,1,2,0,1,2; one req_ready per acceptance.
- pready=1 with pslverr=1 on a write → rsp_err=1 and the next arbitration proceeds normally.
- TIMEOUT_CYCLES=4, pready stuck at 0 → exactly 4 ACCESS cycles, psel=0 afterwards, rsp_valid with rsp_err=1 and rsp_rdata=0, FSM back in IDLE.
- presetn pulsed low during ACCESS → all outputs at reset values within the same cycle, no rsp_valid; next grant goes to requester 0.
